// File: rtl/complex_accumulate.sv
// Frame accumulator for a complex product stream: sums {real, imag} halves through two
// pipelined floating-point adders. Optional synchronous frame abort via COMPLEX_ACCUMULATE_CLEAR_EN.

module add #(
    parameter int    BITS      = 32,
    parameter string PRECISION = "SINGLE"
) (
    input  logic            clk,
    input  logic            in_valid,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    output logic [BITS-1:0] c
);
    localparam int EW = (PRECISION == "DOUBLE") ? 11 : ((PRECISION == "HALF") ? 5 : 8);
    localparam int MW = BITS - 1 - EW;
    localparam int F  = MW + 1;
    localparam int E  = MW + 4;
    localparam int XW = EW + 2;

    function automatic int lzc(input logic [E-1:0] v);
        int   n;
        logic found;
        n     = E;
        found = 1'b0;
        for (int i = E - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = E - 1 - i;
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Normalise the raw magnitude sum, then round to nearest even and pack.
    function automatic logic [BITS-1:0] round_pack(
        input logic          s,
        input logic          zs,
        input logic [EW-1:0] ex,
        input logic [E:0]    sum
    );
        logic [E-1:0]  m;
        logic [XW-1:0] e;
        logic [F:0]    mr;
        logic [XW-1:0] eo;
        logic          rnd;
        int            lz;
        int            sh;
        if (sum == '0) return {zs, {(BITS-1){1'b0}}};
        if (sum[E]) begin
            m = sum[E:1] | E'(sum[0]);
            e = XW'(ex) + XW'(1);
        end else begin
            lz = lzc(sum[E-1:0]);
            sh = (lz < int'(ex) - 1) ? lz : int'(ex) - 1;
            m  = sum[E-1:0] << sh;
            e  = XW'(ex) - XW'(sh);
        end
        rnd = m[2] & (m[1] | m[0] | m[3]);
        mr  = {1'b0, m[E-1:3]} + (F+1)'(rnd);
        eo  = mr[F] ? (e + XW'(1)) : (mr[F-1] ? e : '0);
        if (eo >= XW'({EW{1'b1}})) return {s, {EW{1'b1}}, {MW{1'b0}}};
        return {s, eo[EW-1:0], mr[MW-1:0]};
    endfunction

    logic            swap;
    logic [BITS-1:0] x, y;
    logic [EW-1:0]   ex_e, ey_e, diff;
    logic [E-1:0]    mx, my, my_al;
    logic [2*E-1:0]  wide;
    logic            a_nan, b_nan, a_inf, b_inf, spec;
    logic [BITS-1:0] spec_val;

    always_comb begin
        swap  = b[BITS-2:0] > a[BITS-2:0];
        x     = swap ? b : a;
        y     = swap ? a : b;
        ex_e  = (x[BITS-2:MW] == '0) ? EW'(1) : x[BITS-2:MW];
        ey_e  = (y[BITS-2:MW] == '0) ? EW'(1) : y[BITS-2:MW];
        mx    = {|x[BITS-2:MW], x[MW-1:0], 3'b000};
        my    = {|y[BITS-2:MW], y[MW-1:0], 3'b000};
        diff  = ex_e - ey_e;
        wide  = {my, {E{1'b0}}} >> diff;
        my_al = wide[2*E-1:E] | E'((diff >= EW'(E)) ? |my : |wide[E-1:0]);
        a_nan = (&a[BITS-2:MW]) & (|a[MW-1:0]);
        b_nan = (&b[BITS-2:MW]) & (|b[MW-1:0]);
        a_inf = (&a[BITS-2:MW]) & ~(|a[MW-1:0]);
        b_inf = (&b[BITS-2:MW]) & ~(|b[MW-1:0]);
        spec  = a_nan | b_nan | a_inf | b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (a[BITS-1] != b[BITS-1])))
            spec_val = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        else if (a_inf)
            spec_val = a;
        else
            spec_val = b;
    end

    logic            vld_p0, sx_p0, sub_p0, zs_p0, spec_p0;
    logic [EW-1:0]   ex_p0;
    logic [E-1:0]    mx_p0, my_p0;
    logic [BITS-1:0] sval_p0;
    logic            vld_p1, sx_p1, zs_p1, spec_p1;
    logic [EW-1:0]   ex_p1;
    logic [E:0]      sum_p1;
    logic [BITS-1:0] sval_p1;
    logic            vld_p2;
    logic [BITS-1:0] c_p2;

    // p0: operands ordered by magnitude, smaller one aligned
    always_ff @(posedge clk) begin
        vld_p0  <= in_valid;
        sx_p0   <= x[BITS-1];
        sub_p0  <= x[BITS-1] ^ y[BITS-1];
        zs_p0   <= x[BITS-1] & y[BITS-1];
        ex_p0   <= ex_e;
        mx_p0   <= mx;
        my_p0   <= my_al;
        spec_p0 <= spec;
        sval_p0 <= spec_val;
    end

    // p1: magnitude add or subtract
    always_ff @(posedge clk) begin
        vld_p1  <= vld_p0;
        sum_p1  <= sub_p0 ? ({1'b0, mx_p0} - {1'b0, my_p0}) : ({1'b0, mx_p0} + {1'b0, my_p0});
        sx_p1   <= sx_p0;
        zs_p1   <= zs_p0;
        ex_p1   <= ex_p0;
        spec_p1 <= spec_p0;
        sval_p1 <= sval_p0;
    end

    // p2: normalise, round, pack
    always_ff @(posedge clk) begin
        vld_p2 <= vld_p1;
        c_p2   <= spec_p1 ? sval_p1 : round_pack(sx_p1, zs_p1, ex_p1, sum_p1);
    end

    assign out_valid = vld_p2;
    assign c         = c_p2;
endmodule

module complex_accumulate #(
    parameter int    BITS         = 64,
    parameter string PRECISION    = "SINGLE",
    parameter int    CNT_BITS     = 16,
    parameter int    FLUSH_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rstn,
`ifdef COMPLEX_ACCUMULATE_CLEAR_EN
    input  logic                clr,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     a,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS-1:0]     c,
    output logic [CNT_BITS-1:0] out_count
);
    localparam int H  = BITS / 2;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_EMPTY,
        S_ACCUM,
        S_ADDING,
        S_OUT
`ifdef COMPLEX_ACCUMULATE_CLEAR_EN
        , S_DRAIN
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [BITS-1:0]     acc_q, acc_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                last_q, last_d;
    logic [FW-1:0]       flush_q, flush_d;
    logic                add_go;
    logic                re_vld, im_vld;
    logic [H-1:0]        re_sum, im_sum;

    add #(.BITS(H), .PRECISION(PRECISION)) u_add_re (
        .clk       (clk),
        .in_valid  (add_go),
        .a         (acc_q[BITS-1:H]),
        .b         (a[BITS-1:H]),
        .out_valid (re_vld),
        .c         (re_sum)
    );

    add #(.BITS(H), .PRECISION(PRECISION)) u_add_im (
        .clk       (clk),
        .in_valid  (add_go),
        .a         (acc_q[H-1:0]),
        .b         (a[H-1:0]),
        .out_valid (im_vld),
        .c         (im_sum)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        flush_d   = flush_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_go    = 1'b0;
        case (state_q)
            // The adders have no reset, so their pipelines are left to empty out here.
            S_FLUSH: begin
                if (flush_q == FW'(FLUSH_CYCLES - 1))
                    state_d = S_EMPTY;
                else
                    flush_d = flush_q + FW'(1);
            end
            S_EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = a;
                    cnt_d   = CNT_BITS'(1);
                    state_d = in_last ? S_OUT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    add_go  = 1'b1;
                    last_d  = in_last;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_BITS'(1);
                    state_d = S_ADDING;
                end
            end
            S_ADDING: begin
                if (im_vld)
                    acc_d[H-1:0] = im_sum;
                if (re_vld) begin
                    acc_d[BITS-1:H] = re_sum;
                    state_d         = last_q ? S_OUT : S_ACCUM;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = S_EMPTY;
            end
`ifdef COMPLEX_ACCUMULATE_CLEAR_EN
            S_DRAIN: begin
                if (re_vld)
                    state_d = S_EMPTY;
            end
`endif
            default: state_d = S_FLUSH;
        endcase
`ifdef COMPLEX_ACCUMULATE_CLEAR_EN
        if (clr && (state_q != S_FLUSH)) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            add_go    = 1'b0;
            acc_d     = '0;
            cnt_d     = '0;
            last_d    = 1'b0;
            if ((state_q == S_ADDING || state_q == S_DRAIN) && !re_vld)
                state_d = S_DRAIN;
            else
                state_d = S_EMPTY;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_FLUSH;
            acc_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            flush_q <= flush_d;
        end
    end

    assign c         = acc_q;
    assign out_count = cnt_q;
endmodule

// File: doc/complex_accumulate.md
Name: complex_accumulate

Overview:
- Downstream consumer of the complex multiplier output stream: sums a frame of complex products (real and imaginary separately) into one complex result.
- Used for dot products and correlation.
- Uses the codebase `add` module (two instances: real, imag) with the same BITS/2 and PRECISION.
- Frame delimited by in_last. Result held on a valid/ready output until taken.

Parameters:
- BITS, 64, total complex word width; upper BITS/2 = real, lower BITS/2 = imag.
- PRECISION, "SINGLE", passed to both `add` instances.
- CNT_BITS, 16, width of the sample counter out_count.
- FLUSH_CYCLES, 16, cycles in_ready is held low after reset deassertion; must be >= `add` latency.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  product sample valid (driven from multiplier out_valid)
- in_ready  output  1  block accepts sample this cycle
- a  input  BITS  complex product {real, imag}
- in_last  input  1  sample is the last of its frame
- out_valid  output  1  accumulated result valid
- out_ready  input  1  downstream accepts result
- c  output  BITS  accumulated complex sum {real, imag}
- out_count  output  CNT_BITS  number of samples in the frame

Behaviour:
- Reset (async, rstn=0): state FLUSH; in_ready=0, out_valid=0, c=0, out_count=0; accumulator and counter cleared.
- Accept rule: a sample is accepted when in_valid && in_ready. A sample is never accepted in the same cycle out_valid=1.
- States:
  - FLUSH: count FLUSH_CYCLES cycles, then go to EMPTY. Drains stale `add` outputs (`add` has no reset). All `add` out_valid ignored.
  - EMPTY: in_ready=1. On accept: acc <= a directly (no add); cnt <= 1.
    - If in_last: go to OUT.
    - Else: go to ACCUM.
  - ACCUM: in_ready=1. On accept: issue acc+a to both adders (in_valid pulse); latch in_last into last_q; cnt <= cnt+1 (saturating at 2^CNT_BITS-1); go to ADDING.
  - ADDING: in_ready=0. Wait for real-adder out_valid (both adders share latency; only the real one is monitored). On it: acc <= {real sum, imag sum}.
    - If last_q: go to OUT.
    - Else: go to ACCUM.
  - OUT: out_valid=1; c=acc and out_count=cnt, both stable while out_valid=1. On out_ready: out_valid=0, go to EMPTY (next cycle in_ready=1).
- Throughput: one sample per (add latency + 1) cycles during accumulation. First sample of a frame costs one cycle.
- Single-sample frame (in_last on first sample): EMPTY to OUT; c=a, out_count=1.
- `add` out_valid outside ADDING is ignored.
- in_valid while in_ready=0: sample not consumed. Upstream must hold it, or buffer it if its own protocol cannot stall.
- Reset asserted mid-frame or in OUT: immediate return to reset state; partial sum discarded.
- Arithmetic: IEEE behaviour as implemented by `add` for the chosen PRECISION. No saturation or rounding in this block.

Optional Feature:
- Macro: COMPLEX_ACCUMULATE_CLEAR_EN.
- When defined:
  - Extra port clr (input, 1): synchronous frame abort, highest priority.
  - clr in EMPTY/ACCUM/OUT: go to EMPTY; acc, cnt cleared; out_valid=0.
  - clr in ADDING: go to DRAIN (in_ready=0) until the in-flight `add` out_valid arrives and is discarded, then EMPTY.
  - Samples presented with clr=1 are not accepted.
- When undefined: no clr port, no DRAIN state.

Test Plan:
- Reset release: in_ready=0 for exactly FLUSH_CYCLES cycles, then 1. out_valid=0 and c=0 throughout.
- Two-sample frame:
  - Stimulus: 0x3F800000_40000000 (1,2), then 0x40400000_BF800000 (3,-1) with in_last.
  - Expect: out_valid with c=0x40800000_3F800000 (4,1), out_count=2.
  - Check in_ready=0 for exactly the add latency after the 2nd accept.
- Single-sample frame: a=0x40A00000_00000000 with in_last. Expect c equal to a, out_count=1, output one cycle after accept.
- Output backpressure: hold out_ready=0 for 10 cycles. c/out_count stable, in_ready=0, in_valid ignored. After out_ready=1, the next frame accumulates from zero.
- Frame of 4 samples of (1,1): c=0x40800000_40800000, out_count=4. Back-to-back second frame of 3 samples of (1,1) gives 0x40400000_40400000, out_count=3.
- With COMPLEX_ACCUMULATE_CLEAR_EN: clr pulsed during ADDING. Late `add` result dropped. A following single sample (2,0) gives c=0x40000000_00000000, out_count=1.
